dmem_rr_arbiter: RTL and testbench

Single-channel data-memory arbiter that shares one external read/write memory port among the per-thread LSU request channels of the GPU. It sits between the LSU channel arrays and the data memory, grants one LSU at a time in round-robin order, and carries one read or write transaction per grant through a valid/ready handshake on both sides. It replaces a fixed-priority scan so that no LSU can be starved under full contention.

---
 rtl/dmem_rr_arbiter_if.sv | 42 ++++
 rtl/dmem_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_rr_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_rr_arbiter_if.sv
// rtl/dmem_rr_arbiter_if.sv - LSU-side and memory-side handshake bundle for dmem_rr_arbiter
interface dmem_rr_arbiter_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// rtl/dmem_rr_arbiter.sv - round-robin arbiter sharing one data-memory port among LSU channels
// One read or write is carried per grant; the scan starts just past the last granted channel.
module dmem_rr_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  dmem_rr_arbiter_if.master                bus,
  output logic [$clog2(NUM_CONSUMERS)-1:0] grant_id
);
  localparam int GW = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  state_t                                  state, state_nxt;
  logic [GW-1:0]                           grant_r, grant_nxt;
  logic [GW-1:0]                           last_grant, last_grant_nxt;
  logic                                    mem_read_valid_r, mem_read_valid_nxt;
  logic                                    mem_write_valid_r, mem_write_valid_nxt;
  logic [ADDR_BITS-1:0]                    mem_read_address_r, mem_read_address_nxt;
  logic [ADDR_BITS-1:0]                    mem_write_address_r, mem_write_address_nxt;
  logic [DATA_BITS-1:0]                    mem_write_data_r, mem_write_data_nxt;
  logic [NUM_CONSUMERS-1:0]                read_ready_r, read_ready_nxt;
  logic [NUM_CONSUMERS-1:0]                write_ready_r, write_ready_nxt;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_r, read_data_nxt;

  logic          scan_found;
  logic [GW-1:0] scan_win;
  logic [GW-1:0] scan_idx;
  logic          relay_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      grant_r             <= '0;
      last_grant          <= GW'(NUM_CONSUMERS - 1);
      mem_read_valid_r    <= 1'b0;
      mem_write_valid_r   <= 1'b0;
      mem_read_address_r  <= '0;
      mem_write_address_r <= '0;
      mem_write_data_r    <= '0;
      read_ready_r        <= '0;
      write_ready_r       <= '0;
      read_data_r         <= '0;
    end else begin
      state               <= state_nxt;
      grant_r             <= grant_nxt;
      last_grant          <= last_grant_nxt;
      mem_read_valid_r    <= mem_read_valid_nxt;
      mem_write_valid_r   <= mem_write_valid_nxt;
      mem_read_address_r  <= mem_read_address_nxt;
      mem_write_address_r <= mem_write_address_nxt;
      mem_write_data_r    <= mem_write_data_nxt;
      read_ready_r        <= read_ready_nxt;
      write_ready_r       <= write_ready_nxt;
      read_data_r         <= read_data_nxt;
    end
  end

  always_comb begin
    state_nxt             = state;
    grant_nxt             = grant_r;
    last_grant_nxt        = last_grant;
    mem_read_valid_nxt    = mem_read_valid_r;
    mem_write_valid_nxt   = mem_write_valid_r;
    mem_read_address_nxt  = mem_read_address_r;
    mem_write_address_nxt = mem_write_address_r;
    mem_write_data_nxt    = mem_write_data_r;
    read_ready_nxt        = read_ready_r;
    write_ready_nxt       = write_ready_r;
    read_data_nxt         = read_data_r;

    // First requester found walking forward from the channel after last_grant.
    scan_found = 1'b0;
    scan_win   = '0;
    scan_idx   = '0;
    for (int i = 1; i <= NUM_CONSUMERS; i++) begin
      scan_idx = GW'((int'(last_grant) + i) % NUM_CONSUMERS);
      if (!scan_found &&
          (bus.consumer_read_valid[scan_idx] || bus.consumer_write_valid[scan_idx])) begin
        scan_found = 1'b1;
        scan_win   = scan_idx;
      end
    end

    // The ready bit set on RELAY entry tells which valid must fall to release it.
    relay_valid = (|read_ready_r) ? bus.consumer_read_valid[grant_r]
                                  : bus.consumer_write_valid[grant_r];

    case (state)
      IDLE: begin
        if (scan_found) begin
          grant_nxt      = scan_win;
          last_grant_nxt = scan_win;
          if (bus.consumer_read_valid[scan_win]) begin
            mem_read_valid_nxt   = 1'b1;
            mem_read_address_nxt = bus.consumer_read_address[scan_win];
            state_nxt            = READ_WAIT;
          end else begin
            mem_write_valid_nxt   = 1'b1;
            mem_write_address_nxt = bus.consumer_write_address[scan_win];
            mem_write_data_nxt    = bus.consumer_write_data[scan_win];
            state_nxt             = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (bus.mem_read_ready) begin
          read_data_nxt[grant_r]  = bus.mem_read_data;
          read_ready_nxt[grant_r] = 1'b1;
          mem_read_valid_nxt      = 1'b0;
          state_nxt               = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (bus.mem_write_ready) begin
          write_ready_nxt[grant_r] = 1'b1;
          mem_write_valid_nxt      = 1'b0;
          state_nxt                = RELAY;
        end
      end
      RELAY: begin
        if (!relay_valid) begin
          read_ready_nxt  = '0;
          write_ready_nxt = '0;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_read_valid       = mem_read_valid_r;
  assign bus.mem_read_address     = mem_read_address_r;
  assign bus.mem_write_valid      = mem_write_valid_r;
  assign bus.mem_write_address    = mem_write_address_r;
  assign bus.mem_write_data       = mem_write_data_r;
  assign bus.consumer_read_ready  = read_ready_r;
  assign bus.consumer_write_ready = write_ready_r;
  assign bus.consumer_read_data   = read_data_r;
  assign grant_id                 = grant_r;
endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// tb/tb_dmem_rr_arbiter.sv - directed and randomized checks of dmem_rr_arbiter
// Random traffic is judged by a transaction-level model: round-robin pick, latencies, fairness.
module tb_dmem_rr_arbiter;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int N  = 8;
  localparam int GW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic [GW-1:0] grant_id;

  dmem_rr_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) bus ();

  dmem_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  bit mon_en       = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first requester strictly after the previous grant, wrapping.
  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready         = 1'b0;
    bus.mem_read_data          = '0;
    bus.mem_write_ready        = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Waits for the next memory request, checks its routing, answers after lat cycles,
  // then checks the consumer-side completion one edge later.
  task automatic serve(input int exp_grant, input bit exp_rd, input int lat, input logic [DB-1:0] rdata);
    int waited;
    waited = 0;
    while (!(bus.mem_read_valid || bus.mem_write_valid) && waited < 40) begin
      tick();
      waited++;
    end
    check_eq("serve_grant_seen", waited < 40, 1'b1);
    if (waited >= 40) return;
    check_eq("serve_grant_id", grant_id, exp_grant);
    check_eq("serve_is_read", bus.mem_read_valid, exp_rd);
    if (exp_rd) begin
      check_eq("serve_read_addr", bus.mem_read_address, bus.consumer_read_address[exp_grant]);
    end else begin
      check_eq("serve_write_addr", bus.mem_write_address, bus.consumer_write_address[exp_grant]);
      check_eq("serve_write_data", bus.mem_write_data, bus.consumer_write_data[exp_grant]);
    end
    repeat (lat) begin
      tick();
      check_eq("serve_valid_held", exp_rd ? bus.mem_read_valid : bus.mem_write_valid, 1'b1);
    end
    if (exp_rd) begin
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = rdata;
    end else begin
      bus.mem_write_ready = 1'b1;
    end
    tick();
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data   = DB'($urandom);
    check_eq("serve_mem_valid_drop", bus.mem_read_valid | bus.mem_write_valid, 1'b0);
    check_eq("serve_read_ready_vec", bus.consumer_read_ready, exp_rd ? onehot(exp_grant) : '0);
    check_eq("serve_write_ready_vec", bus.consumer_write_ready, exp_rd ? '0 : onehot(exp_grant));
    if (exp_rd) check_eq("serve_read_data", bus.consumer_read_data[exp_grant], rdata);
  endtask

  // Structural invariants checked every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("mon_mem_valid_excl", bus.mem_read_valid & bus.mem_write_valid, 1'b0);
      check_eq("mon_ready_onehot",
               $countones({bus.consumer_read_ready, bus.consumer_write_ready}) > 1, 1'b0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL tb_watchdog: got timeout, expected run to finish");
    $fatal(1);
  end

  typedef enum {M_IDLE, M_WAIT, M_RELAY} phase_t;

  phase_t          ph;
  int              cur, lat, hold, model_last, grants, exp_g;
  bit              cur_rd, ready_driven, rel_valid;
  logic [DB-1:0]   resp;
  logic [N-1:0]    prev_rv, prev_wv;
  logic [DB-1:0]   exp_rd_data [N];
  logic [N*DB-1:0] exp_vec;
  int              wait_cnt [N];
  int              rcool [N];
  int              wcool [N];

  initial begin
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;

    // Reset values
    check_eq("rst_mem_read_valid", bus.mem_read_valid, 1'b0);
    check_eq("rst_mem_write_valid", bus.mem_write_valid, 1'b0);
    check_eq("rst_mem_read_addr", bus.mem_read_address, 0);
    check_eq("rst_mem_write_addr", bus.mem_write_address, 0);
    check_eq("rst_mem_write_data", bus.mem_write_data, 0);
    check_eq("rst_read_ready", bus.consumer_read_ready, 0);
    check_eq("rst_write_ready", bus.consumer_write_ready, 0);
    check_eq("rst_read_data", bus.consumer_read_data, 0);
    check_eq("rst_grant_id", grant_id, 0);
    reset = 1'b1;
    tick();

    // Single read: consumer 2, address 0x10, memory answers after 3 cycles
    bus.consumer_read_address[2] = 8'h10;
    bus.consumer_read_valid[2]   = 1'b1;
    tick();
    check_eq("single_req_latency", bus.mem_read_valid, 1'b1);
    check_eq("single_req_addr", bus.mem_read_address, 8'h10);
    serve(2, 1'b1, 3, 8'h5A);
    repeat (2) begin
      tick();
      check_eq("single_ready_hold", bus.consumer_read_ready, onehot(2));
    end
    bus.consumer_read_valid[2] = 1'b0;
    tick();
    check_eq("single_ready_drop", bus.consumer_read_ready, 0);
    check_eq("single_grant_sticky", grant_id, 2);
    check_eq("single_data_kept", bus.consumer_read_data[2], 8'h5A);

    // Round robin among 0, 3, 5, with 0 re-raised after it completes
    do_reset();
    for (int i = 0; i < N; i++) bus.consumer_read_address[i] = AB'(8'h80 + i);
    bus.consumer_read_valid[0] = 1'b1;
    bus.consumer_read_valid[3] = 1'b1;
    bus.consumer_read_valid[5] = 1'b1;
    serve(0, 1'b1, 0, 8'hA0);
    bus.consumer_read_valid[0] = 1'b0;
    tick();
    bus.consumer_read_valid[0] = 1'b1;
    serve(3, 1'b1, 0, 8'hA3);
    bus.consumer_read_valid[3] = 1'b0;
    serve(5, 1'b1, 0, 8'hA5);
    bus.consumer_read_valid[5] = 1'b0;
    serve(0, 1'b1, 0, 8'hB0);
    bus.consumer_read_valid[0] = 1'b0;
    tick();

    // Read and write on consumer 1 at once: read first, write on a later grant
    bus.consumer_read_address[1]  = 8'h20;
    bus.consumer_write_address[1] = 8'h21;
    bus.consumer_write_data[1]    = 8'h33;
    bus.consumer_read_valid[1]    = 1'b1;
    bus.consumer_write_valid[1]   = 1'b1;
    serve(1, 1'b1, 1, 8'hC4);
    bus.consumer_read_valid[1] = 1'b0;
    serve(1, 1'b0, 2, 8'h00);
    check_eq("rw_write_addr_seen", bus.mem_write_address, 8'h21);
    bus.consumer_write_valid[1] = 1'b0;
    tick();

    // Full contention: every consumer reads continuously
    do_reset();
    bus.consumer_read_valid = '1;
    exp_g = N - 1;
    for (int k = 0; k < 2 * N; k++) begin
      exp_g = (exp_g + 1) % N;
      serve(exp_g, 1'b1, k % 3, DB'(k * 7 + 1));
      bus.consumer_read_valid[exp_g] = 1'b0;
      tick();
      bus.consumer_read_valid[exp_g] = 1'b1;
    end
    bus.consumer_read_valid = '0;
    tick();
    tick();

    // Reset while a read is outstanding
    bus.consumer_read_address[4] = 8'h44;
    bus.consumer_read_valid[4]   = 1'b1;
    tick();
    check_eq("midrst_req_up", bus.mem_read_valid, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    check_eq("midrst_mem_read_valid", bus.mem_read_valid, 1'b0);
    check_eq("midrst_mem_read_addr", bus.mem_read_address, 0);
    check_eq("midrst_ready", {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
    check_eq("midrst_read_data", bus.consumer_read_data, 0);
    check_eq("midrst_grant_id", grant_id, 0);
    tick();
    bus.consumer_read_address[0] = 8'h01;
    bus.consumer_read_valid[0]   = 1'b1;
    reset = 1'b1;
    serve(0, 1'b1, 0, 8'h11);
    bus.consumer_read_valid[0] = 1'b0;
    serve(4, 1'b1, 1, 8'h44);
    bus.consumer_read_valid[4] = 1'b0;
    tick();

    // Valid dropped in the cycle ready rises: one-cycle ready, then IDLE
    bus.consumer_read_address[6] = 8'h66;
    bus.consumer_read_valid[6]   = 1'b1;
    serve(6, 1'b1, 0, 8'h6E);
    bus.consumer_read_valid[6] = 1'b0;
    tick();
    check_eq("early_drop_ready", bus.consumer_read_ready, 0);
    bus.consumer_read_address[7] = 8'h77;
    bus.consumer_read_valid[7]   = 1'b1;
    tick();
    check_eq("early_drop_regrant", bus.mem_read_valid, 1'b1);
    check_eq("early_drop_grant_id", grant_id, 7);
    serve(7, 1'b1, 0, 8'h7E);
    bus.consumer_read_valid[7] = 1'b0;
    tick();
    tick();

    // Memory ready outside a wait state is ignored
    bus.mem_read_ready  = 1'b1;
    bus.mem_write_ready = 1'b1;
    repeat (3) begin
      tick();
      check_eq("stray_mem_ready", {bus.consumer_read_ready, bus.consumer_write_ready,
                                   bus.mem_read_valid, bus.mem_write_valid}, 0);
    end
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;

    // Randomized traffic against the transaction-level model
    do_reset();
    ph           = M_IDLE;
    model_last   = N - 1;
    grants       = 0;
    ready_driven = 1'b0;
    prev_rv      = '0;
    prev_wv      = '0;
    cur          = 0;
    cur_rd       = 1'b0;
    lat          = 0;
    hold         = 0;
    resp         = '0;
    for (int i = 0; i < N; i++) begin
      exp_rd_data[i] = '0;
      wait_cnt[i]    = 0;
      rcool[i]       = 0;
      wcool[i]       = 0;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      case (ph)
        M_IDLE: begin
          if ((prev_rv | prev_wv) != '0) begin
            cur    = rr_pick(model_last, prev_rv | prev_wv);
            cur_rd = prev_rv[cur];
            check_eq("rnd_grant_issued", bus.mem_read_valid | bus.mem_write_valid, 1'b1);
            check_eq("rnd_grant_id", grant_id, cur);
            check_eq("rnd_grant_kind", bus.mem_read_valid, cur_rd);
            if (cur_rd) begin
              check_eq("rnd_read_addr", bus.mem_read_address, bus.consumer_read_address[cur]);
            end else begin
              check_eq("rnd_write_addr", bus.mem_write_address, bus.consumer_write_address[cur]);
              check_eq("rnd_write_data", bus.mem_write_data, bus.consumer_write_data[cur]);
            end
            for (int j = 0; j < N; j++) begin
              if (j != cur && (prev_rv[j] || prev_wv[j])) wait_cnt[j]++;
            end
            check_eq("rnd_fairness", wait_cnt[cur] <= N - 1, 1'b1);
            wait_cnt[cur] = 0;
            model_last    = cur;
            lat           = $urandom_range(0, 3);
            grants++;
            ph = M_WAIT;
          end else begin
            check_eq("rnd_no_spurious_grant", bus.mem_read_valid | bus.mem_write_valid, 1'b0);
          end
        end
        M_WAIT: begin
          if (ready_driven) begin
            check_eq("rnd_mem_valid_drop", bus.mem_read_valid | bus.mem_write_valid, 1'b0);
            check_eq("rnd_read_ready_vec", bus.consumer_read_ready, cur_rd ? onehot(cur) : '0);
            check_eq("rnd_write_ready_vec", bus.consumer_write_ready, cur_rd ? '0 : onehot(cur));
            if (cur_rd) exp_rd_data[cur] = resp;
            for (int i = 0; i < N; i++) exp_vec[i*DB +: DB] = exp_rd_data[i];
            check_eq("rnd_read_data_all", bus.consumer_read_data, exp_vec);
            hold = $urandom_range(0, 2);
            ph   = M_RELAY;
          end else begin
            check_eq("rnd_wait_valid_held", cur_rd ? bus.mem_read_valid : bus.mem_write_valid, 1'b1);
            check_eq("rnd_wait_addr_held", cur_rd ? bus.mem_read_address : bus.mem_write_address,
                     cur_rd ? bus.consumer_read_address[cur] : bus.consumer_write_address[cur]);
            check_eq("rnd_wait_no_ready", {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
          end
        end
        M_RELAY: begin
          rel_valid = cur_rd ? prev_rv[cur] : prev_wv[cur];
          if (!rel_valid) begin
            check_eq("rnd_relay_release", {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
            ph = M_IDLE;
          end else begin
            check_eq("rnd_relay_hold_rd", bus.consumer_read_ready, cur_rd ? onehot(cur) : '0);
            check_eq("rnd_relay_hold_wr", bus.consumer_write_ready, cur_rd ? '0 : onehot(cur));
          end
        end
        default: ph = M_IDLE;
      endcase

      // Memory responder, with stray ready pulses on whichever side is not being waited on
      ready_driven        = 1'b0;
      bus.mem_read_ready  = 1'b0;
      bus.mem_write_ready = 1'b0;
      if (ph == M_WAIT) begin
        if (lat == 0) begin
          ready_driven = 1'b1;
          if (cur_rd) begin
            resp               = DB'($urandom);
            bus.mem_read_ready = 1'b1;
            bus.mem_read_data  = resp;
          end else begin
            bus.mem_write_ready = 1'b1;
          end
        end else begin
          lat--;
        end
      end
      if (!(ph == M_WAIT && cur_rd) && $urandom_range(0, 3) == 0) begin
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = DB'($urandom);
      end
      if (!(ph == M_WAIT && !cur_rd) && $urandom_range(0, 3) == 0) bus.mem_write_ready = 1'b1;

      // Consumer agents
      if (ph == M_RELAY) begin
        if (hold == 0) begin
          if (cur_rd) begin
            bus.consumer_read_valid[cur] = 1'b0;
            rcool[cur] = $urandom_range(1, 3);
          end else begin
            bus.consumer_write_valid[cur] = 1'b0;
            wcool[cur] = $urandom_range(1, 3);
          end
        end else begin
          hold--;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rcool[i] > 0) rcool[i]--;
        else if (!bus.consumer_read_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.consumer_read_address[i] = AB'($urandom);
          bus.consumer_read_valid[i]   = 1'b1;
        end
        if (wcool[i] > 0) wcool[i]--;
        else if (!bus.consumer_write_valid[i] && $urandom_range(0, 3) == 0) begin
          bus.consumer_write_address[i] = AB'($urandom);
          bus.consumer_write_data[i]    = DB'($urandom);
          bus.consumer_write_valid[i]   = 1'b1;
        end
      end
      prev_rv = bus.consumer_read_valid;
      prev_wv = bus.consumer_write_valid;
    end
    check_eq("rnd_grant_count", grants > 100, 1'b1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
